// File: rtl/dcm_reset_seq_pkg.sv
// Shared types and constants for the DCM reset sequencer: state encoding,
// status widths and a small helper for sizing the cycle counter.
package dcm_reset_seq_pkg;

  localparam int StateWidth    = 3;
  localparam int LockLossWidth = 8;

  typedef enum logic [StateWidth-1:0] {
    DCMRST   = 3'd0,
    WAITLOCK = 3'd1,
    STABLE   = 3'd2,
    RUN      = 3'd3,
    FAIL     = 3'd4
  } state_t;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dcm_reset_sequencer_if.sv
// Signals between the reset sequencer, the DCM wrapper and the reset consumers.
interface dcm_reset_sequencer_if;

  logic locked;
  logic dcm_reset;
  logic sys_reset;
  logic ready;
  logic fail;

  modport master (input locked, output dcm_reset, output sys_reset, output ready, output fail);
  modport slave  (output locked, input dcm_reset, input sys_reset, input ready, input fail);

endinterface

// File: rtl/dcm_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a configurable reset value.
module sync_2ff #(
  parameter logic ResetValue = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= ResetValue;
      q    <= ResetValue;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dcm_reset_sequencer.sv
// Drives DCM reset, waits for a stable lock, then releases the system reset; retries on timeout.
// Optional status ports (lock_loss_count, state_dbg) exist when DCM_RESET_SEQ_STATUS_EN is defined.
module dcm_reset_sequencer
  import dcm_reset_seq_pkg::*;
#(
  parameter int DcmResetCycles   = 4,
  parameter int LockTimeout      = 65536,
  parameter int LockStableCycles = 1024,
  parameter int MaxRetries       = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  dcm_reset_sequencer_if.master     bus
`ifdef DCM_RESET_SEQ_STATUS_EN
  ,
  output logic [LockLossWidth-1:0]  lock_loss_count,
  output logic [StateWidth-1:0]     state_dbg
`endif
);

  localparam int CntMax     = max_of3(DcmResetCycles, LockTimeout, LockStableCycles);
  localparam int CntWidth   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int RetryWidth = $clog2(MaxRetries + 1);

  localparam logic [CntWidth-1:0]   DcmRstLast = CntWidth'(DcmResetCycles - 1);
  localparam logic [CntWidth-1:0]   TimeoutLast = CntWidth'(LockTimeout - 1);
  localparam logic [CntWidth-1:0]   StableLast = CntWidth'(LockStableCycles - 1);
  localparam logic [RetryWidth-1:0] RetryLast = RetryWidth'(MaxRetries - 1);

  state_t                state;
  state_t                next_state;
  logic [CntWidth-1:0]   cnt;
  logic [RetryWidth-1:0] retries;
  logic [RetryWidth-1:0] next_retries;
  logic                  locked_s;
  logic                  dcm_reset_q;
  logic                  sys_reset_q;
  logic                  ready_q;
  logic                  fail_q;

  sync_2ff #(.ResetValue(1'b0)) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.locked),
    .q     (locked_s)
  );

  // Lock presence outranks the timeout in WAITLOCK; FAIL only leaves through reset.
  always_comb begin
    next_state   = state;
    next_retries = retries;
    unique case (state)
      DCMRST: begin
        if (cnt == DcmRstLast) next_state = WAITLOCK;
      end
      WAITLOCK: begin
        if (locked_s) begin
          next_state = STABLE;
        end else if (cnt == TimeoutLast) begin
          if (retries == RetryLast) begin
            next_state = FAIL;
          end else begin
            next_state   = DCMRST;
            next_retries = retries + 1'b1;
          end
        end
      end
      STABLE: begin
        if (!locked_s)               next_state = WAITLOCK;
        else if (cnt == StableLast)  next_state = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          next_state   = DCMRST;
          next_retries = '0;
        end
      end
      FAIL: begin
        next_state = FAIL;
      end
      default: begin
        next_state = DCMRST;
      end
    endcase
  end

  // Outputs are registered from the next state so they move in the same cycle as the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= DCMRST;
      cnt         <= '0;
      retries     <= '0;
      dcm_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state   <= next_state;
      retries <= next_retries;
      if (next_state != state) begin
        cnt <= '0;
      end else if (state inside {DCMRST, WAITLOCK, STABLE}) begin
        cnt <= cnt + 1'b1;
      end
      dcm_reset_q <= (next_state == DCMRST);
      sys_reset_q <= (next_state != RUN);
      ready_q     <= (next_state == RUN);
      fail_q      <= (next_state == FAIL);
    end
  end

  assign bus.dcm_reset = dcm_reset_q;
  assign bus.sys_reset = sys_reset_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;

`ifdef DCM_RESET_SEQ_STATUS_EN
  logic [LockLossWidth-1:0] loss_cnt;

  // Saturating count of lock losses seen while running.
  always_ff @(posedge clock) begin
    if (reset) begin
      loss_cnt <= '0;
    end else if (state == RUN && next_state == DCMRST && loss_cnt != '1) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end

  assign lock_loss_count = loss_cnt;
  assign state_dbg       = state;
`endif

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Scoreboard bench for dcm_reset_sequencer: per-cycle expected outputs are queued by each
// scenario and popped as the DUT reaches that cycle.
module tb_dcm_reset_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] val;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  dcm_reset_sequencer_if bus ();

`ifdef DCM_RESET_SEQ_STATUS_EN
  logic [7:0] lock_loss_count;
  logic [2:0] state_dbg;
`endif

  dcm_reset_sequencer #(
    .DcmResetCycles   (3),
    .LockTimeout      (16),
    .LockStableCycles (8),
    .MaxRetries       (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus)
`ifdef DCM_RESET_SEQ_STATUS_EN
    ,
    .lock_loss_count (lock_loss_count),
    .state_dbg       (state_dbg)
`endif
  );

  always #5 clock = ~clock;

  // Output vector order: {dcm_reset, sys_reset, ready, fail}
  function automatic logic [3:0] outs();
    return {bus.dcm_reset, bus.sys_reset, bus.ready, bus.fail};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic expect_range(input string name, input int from, input int to, input logic [3:0] val);
    for (int c = from; c <= to; c++) exp_q.push_back(exp_t'{c, val, name});
  endtask

  // Holds reset for n edges; afterwards we sit in cycle 0.
  task automatic start(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    bus.locked = 1'b0;
    reset = 1'b1;
    step();
    exp_q.push_back(exp_t'{0, 4'b1100, "reset_state_a"});
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e.val) begin
      errors++;
      $display("[TB] FAIL %s got %b want %b", e.name, outs(), e.val);
    end
    step();
    exp_q.push_back(exp_t'{0, 4'b1100, "reset_state_b"});
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e.val) begin
      errors++;
      $display("[TB] FAIL %s got %b want %b", e.name, outs(), e.val);
    end
  endtask

  task automatic test_lock_ok();
    exp_t e;
    bus.locked = 1'b1;
    start(2);
    expect_range("ok_dcmrst", 0, 2, 4'b1100);
    expect_range("ok_wait_stable", 3, 11, 4'b0100);
    expect_range("ok_run", 12, 15, 4'b0010);
    for (int c = 0; c <= 15; c++) begin
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.val) begin
          errors++;
          $display("[TB] FAIL %s cyc %0d got %b want %b", e.name, c, outs(), e.val);
        end
      end
`ifdef DCM_RESET_SEQ_STATUS_EN
      if (c == 4 || c == 12) begin
        checks++;
        if (state_dbg !== ((c == 4) ? 3'd2 : 3'd3)) begin
          errors++;
          $display("[TB] FAIL state_dbg cyc %0d got %0d", c, state_dbg);
        end
      end
`endif
      if (c < 15) step();
    end
  endtask

  task automatic test_lock_timeout();
    exp_t e;
    bus.locked = 1'b0;
    start(2);
    expect_range("to_dcmrst1", 0, 2, 4'b1100);
    expect_range("to_wait1", 3, 18, 4'b0100);
    expect_range("to_dcmrst2", 19, 21, 4'b1100);
    expect_range("to_wait2", 22, 37, 4'b0100);
    expect_range("to_fail", 38, 45, 4'b0101);
    for (int c = 0; c <= 45; c++) begin
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.val) begin
          errors++;
          $display("[TB] FAIL %s cyc %0d got %b want %b", e.name, c, outs(), e.val);
        end
      end
      if (c < 45) step();
    end
  endtask

  // Entered from FAIL with retries=1; a cleared retry count must allow another attempt.
  task automatic test_reset_from_fail();
    exp_t e;
    bus.locked = 1'b0;
    start(1);
    expect_range("rf_dcmrst1", 0, 2, 4'b1100);
    expect_range("rf_wait1", 3, 18, 4'b0100);
    expect_range("rf_dcmrst2", 19, 21, 4'b1100);
    expect_range("rf_wait2", 22, 37, 4'b0100);
    expect_range("rf_fail", 38, 40, 4'b0101);
    for (int c = 0; c <= 40; c++) begin
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.val) begin
          errors++;
          $display("[TB] FAIL %s cyc %0d got %b want %b", e.name, c, outs(), e.val);
        end
      end
      if (c < 40) step();
    end
  endtask

  task automatic test_stable_glitch();
    exp_t e;
    bus.locked = 1'b1;
    start(2);
    expect_range("sg_dcmrst", 0, 2, 4'b1100);
    expect_range("sg_held", 3, 17, 4'b0100);
    expect_range("sg_run", 18, 22, 4'b0010);
    for (int c = 0; c <= 22; c++) begin
      if (c == 6) bus.locked = 1'b0;
      if (c == 7) bus.locked = 1'b1;
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.val) begin
          errors++;
          $display("[TB] FAIL %s cyc %0d got %b want %b", e.name, c, outs(), e.val);
        end
      end
      if (c < 22) step();
    end
  endtask

  task automatic test_run_lock_loss();
    exp_t e;
    bus.locked = 1'b1;
    start(2);
    expect_range("rl_dcmrst", 0, 2, 4'b1100);
    expect_range("rl_wait", 3, 11, 4'b0100);
    expect_range("rl_run1", 12, 17, 4'b0010);
    expect_range("rl_dcmrst2", 18, 20, 4'b1100);
    expect_range("rl_wait2", 21, 29, 4'b0100);
    expect_range("rl_run2", 30, 33, 4'b0010);
    for (int c = 0; c <= 33; c++) begin
      if (c == 15) bus.locked = 1'b0;
      if (c == 17) bus.locked = 1'b1;
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.val) begin
          errors++;
          $display("[TB] FAIL %s cyc %0d got %b want %b", e.name, c, outs(), e.val);
        end
      end
      if (c < 33) step();
    end
  endtask

  task automatic test_reset_from_run();
    exp_t e;
    bus.locked = 1'b0;
    start(1);
    expect_range("rr_dcmrst1", 0, 2, 4'b1100);
    expect_range("rr_wait1", 3, 18, 4'b0100);
    expect_range("rr_dcmrst2", 19, 21, 4'b1100);
    expect_range("rr_wait2", 22, 24, 4'b0100);
    for (int c = 0; c <= 24; c++) begin
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.val) begin
          errors++;
          $display("[TB] FAIL %s cyc %0d got %b want %b", e.name, c, outs(), e.val);
        end
      end
      if (c < 24) step();
    end
  endtask

`ifdef DCM_RESET_SEQ_STATUS_EN
  task automatic test_lock_loss_count();
    int n;
    int want;
    bus.locked = 1'b1;
    start(2);
    checks++;
    if (lock_loss_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL llc_init got %0d want 0", lock_loss_count);
    end
    for (int k = 1; k <= 301; k++) begin
      n = 0;
      while (!bus.ready && n < 64) begin
        step();
        n++;
      end
      if (!bus.ready) begin
        checks++;
        errors++;
        $display("[TB] FAIL llc_ready_timeout iter %0d got 0 want 1", k);
        break;
      end
      bus.locked = 1'b0;
      step();
      step();
      bus.locked = 1'b1;
      step();
      step();
      want = (k > 255) ? 255 : k;
      if (k == 1 || k == 2 || k == 255 || k == 300 || k == 301) begin
        checks++;
        if (lock_loss_count !== 8'(want)) begin
          errors++;
          $display("[TB] FAIL llc_iter%0d got %0d want %0d", k, lock_loss_count, want);
        end
      end
    end
    start(1);
    checks++;
    if (lock_loss_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL llc_after_reset got %0d want 0", lock_loss_count);
    end
  endtask
`endif

  initial begin
    bus.locked = 1'b0;
    test_reset();
    test_lock_ok();
    test_lock_timeout();
    test_reset_from_fail();
    test_stable_glitch();
    test_run_lock_loss();
    test_reset_from_run();
`ifdef DCM_RESET_SEQ_STATUS_EN
    test_lock_loss_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
